// File: rtl/max_kofn.sv
// Temporal K-of-N order statistic for race-logic columns: fires one pulse per
// gamma cycle when the K-th input arrival is seen, and reports its phase.
module max_kofn #(
    parameter int N_INPUTS          = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic                                 aclk,
    input  logic                                 grst,
    input  logic [N_INPUTS-1:0]                  in,
    input  logic [$clog2(N_INPUTS):0]            k,
    output logic                                 y,
    output logic                                 y_valid,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] y_time,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] phase
);

    localparam int KW  = $clog2(N_INPUTS) + 1;
    localparam int PHW = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int CW  = $clog2(PULSE_WIDTH + 1);

    localparam logic [PHW-1:0] LAST_PH = PHW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [KW-1:0]  K_MAX   = KW'(N_INPUTS);
    localparam logic [CW-1:0]  PW_C    = CW'(PULSE_WIDTH);

    typedef enum logic [1:0] {IDLE, FIRE, DONE} state_t;

    logic [PHW-1:0]      phase_q, phase_d;
    logic [N_INPUTS-1:0] arrived_q, arrived_d;
    logic [KW-1:0]       k_q, k_d;
    state_t              state_q, state_d;
    logic [CW-1:0]       pcnt_q, pcnt_d;
    logic                y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic [PHW-1:0]      y_time_q, y_time_d;

    logic                last;
    logic [N_INPUTS-1:0] hit;
    logic [KW-1:0]       cnt;
    logic                detect;

    always_comb begin
        last    = (phase_q == LAST_PH);
        phase_d = last ? '0 : phase_q + 1'b1;
        // k is live during phase 0 itself so an arrival at phase 0 can fire
        k_d     = (phase_q == '0) ? k : k_q;

        hit = arrived_q | (last ? '0 : in);
        cnt = '0;
        for (int i = 0; i < N_INPUTS; i++)
            cnt = cnt + {{(KW-1){1'b0}}, hit[i]};

        detect = (state_q == IDLE) && (k_d != '0) && (k_d <= K_MAX) && (cnt >= k_d);

        arrived_d = hit;
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        y_d       = 1'b0;
        y_valid_d = 1'b0;
        y_time_d  = y_time_q;

        case (state_q)
            IDLE: if (detect) begin
                state_d   = FIRE;
                pcnt_d    = CW'(1);
                y_d       = 1'b1;
                y_valid_d = 1'b1;
                y_time_d  = phase_q;
            end
            FIRE: if (pcnt_q < PW_C) begin
                y_d    = 1'b1;
                pcnt_d = pcnt_q + 1'b1;
            end else begin
                state_d = DONE;
            end
            DONE:    ;
            default: state_d = IDLE;
        endcase

        // Wrap clears per-gamma state so phase 0 starts idle; truncates pulses
        if (last) begin
            arrived_d = '0;
            state_d   = IDLE;
            pcnt_d    = '0;
            y_d       = 1'b0;
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            phase_q   <= '0;
            arrived_q <= '0;
            k_q       <= '0;
            state_q   <= IDLE;
            pcnt_q    <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
            y_time_q  <= '0;
        end else begin
            phase_q   <= phase_d;
            arrived_q <= arrived_d;
            k_q       <= k_d;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_time_q  <= y_time_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_time  = y_time_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_max_kofn.sv
// Bench for max_kofn (N=4, G=16, P=4): one table record per gamma cycle,
// expected outputs queued as each phase is driven and popped after the edge.
module tb_max_kofn;
    localparam int N = 4;
    localparam int G = 16;
    localparam int P = 4;

    logic       aclk = 1'b0;
    logic       grst;
    logic [3:0] in;
    logic [2:0] k;
    logic       y, y_valid;
    logic [3:0] y_time, phase;

    max_kofn #(.N_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P)) dut (
        .aclk(aclk), .grst(grst), .in(in), .k(k),
        .y(y), .y_valid(y_valid), .y_time(y_time), .phase(phase)
    );

    always #5 aclk = ~aclk;

    // a*: arrival phase per input (-1 none); len: pulse length (0 = hold)
    // f: expected detect phase (-1 no fire); kmid: k written at phase 5
    typedef struct {
        int kv; int kmid; int a0; int a1; int a2; int a3;
        int len; int f; int rst_at;
    } vec_t;

    typedef struct {
        logic       y;
        logic       yv;
        logic [3:0] t;
        logic [3:0] ph;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    int   prev_time = 0;

    function automatic vec_t mk(int kv, int kmid, int a0, int a1, int a2, int a3,
                                int len, int f, int rst_at);
        vec_t v;
        v.kv = kv; v.kmid = kmid; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.len = len; v.f = f; v.rst_at = rst_at;
        return v;
    endfunction

    function automatic logic drv(int a, int len, int p);
        return (a >= 0) && (p >= a) && ((len == 0) || (p < a + len));
    endfunction

    task automatic check(input string name, input int gi, input int p,
                         input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s gamma=%0d phase=%0d got=%0d want=%0d", name, gi, p, act, want);
        end
    endtask

    task automatic pop_check(input int gi, input int p);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard gamma=%0d phase=%0d got=empty want=entry", gi, p);
        end else begin
            e = sb.pop_front();
            check("y",       gi, p, {3'b0, y},       {3'b0, e.y});
            check("y_valid", gi, p, {3'b0, y_valid}, {3'b0, e.yv});
            check("y_time",  gi, p, y_time,          e.t);
            check("phase",   gi, p, phase,           e.ph);
        end
    endtask

    // Drives one gamma cycle starting at a negedge where the DUT sits at phase 0.
    task automatic run_gamma(input vec_t v, input int gi);
        exp_t e;
        int   np;
        logic fired;
        for (int p = 0; p < G; p++) begin
            if (p == v.rst_at) begin
                grst = 1'b1;
                e.y = 1'b0; e.yv = 1'b0; e.t = 4'd0; e.ph = 4'd0;
                sb.push_back(e);
                @(negedge aclk);
                pop_check(gi, p);
                grst = 1'b0;
                in = '0;
                prev_time = 0;
                return;
            end
            if (p == 0) k = 3'(v.kv);
            if (p == 5 && v.kmid >= 0) k = 3'(v.kmid);
            in = {drv(v.a3, v.len, p), drv(v.a2, v.len, p),
                  drv(v.a1, v.len, p), drv(v.a0, v.len, p)};
            np = (p + 1) % G;
            fired = (v.f >= 0) && (np > v.f);
            e.y  = fired && (np <= v.f + P);
            e.yv = fired && (np == v.f + 1);
            e.t  = ((v.f >= 0) && (fired || np == 0)) ? 4'(v.f) : 4'(prev_time);
            e.ph = 4'(np);
            sb.push_back(e);
            @(negedge aclk);
            pop_check(gi, np);
        end
        if (v.f >= 0) prev_time = v.f;
    endtask

    initial begin
        exp_t e;
        grst = 1'b1;
        in   = '0;
        k    = '0;
        repeat (3) @(negedge aclk);
        e.y = 1'b0; e.yv = 1'b0; e.t = 4'd0; e.ph = 4'd0;
        sb.push_back(e);
        pop_check(-1, 0);
        grst = 1'b0;

        //            k  kmid  a0  a1  a2  a3 len   f rst
        tbl.push_back(mk(0, -1,  2,  2,  2,  2, 0, -1, -1));
        tbl.push_back(mk(4, -1,  2,  5,  3,  9, 0,  9, -1));
        tbl.push_back(mk(1, -1, -1,  3,  0, -1, 1,  0, -1));
        tbl.push_back(mk(4, -1,  1,  4,  7, -1, 0, -1, -1));
        tbl.push_back(mk(4, -1, -1, -1, -1,  1, 0, -1, -1));
        tbl.push_back(mk(4, -1,  1,  1,  1,  1, 0,  1, -1));
        tbl.push_back(mk(2, -1,  6,  6,  6,  6, 0,  6, -1));
        tbl.push_back(mk(0, -1,  6,  6,  6,  6, 0, -1, -1));
        tbl.push_back(mk(1, -1, 13, -1, -1, -1, 0, 13, -1));
        tbl.push_back(mk(1, -1, 15, 15, -1, -1, 0, -1, -1));
        tbl.push_back(mk(1, -1, 14, -1, -1, -1, 1, 14, -1));
        tbl.push_back(mk(5, -1,  2,  2,  2,  2, 0, -1, -1));
        tbl.push_back(mk(3, -1,  4,  4,  8, -1, 0,  8, -1));
        tbl.push_back(mk(2, -1,  2, -1, -1, -1, 0, -1, -1));
        tbl.push_back(mk(4, -1,  0,  0,  0,  0, 0,  0, -1));

        foreach (tbl[i]) run_gamma(tbl[i], i);

        // k rewritten mid-gamma only takes effect at the next phase 0
        run_gamma(mk(1, 3, -1, -1, -1,  8, 0,  8, -1), 100);
        run_gamma(mk(3, 1, -1, -1,  9, -1, 0, -1, -1), 101);

        // reset during a pulse, then normal operation resumes from phase 0
        run_gamma(mk(1, -1, 9, -1, -1, -1, 0, 9, 11), 200);
        run_gamma(mk(2, -1, 3,  5, -1, -1, 0, 5, -1), 201);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
